btn_debounce_bank: RTL

- Parametrised multi-channel button conditioner. Replaces the single hard-wired debouncer and pulse pair on the load button with a bank covering every board button.
- Each channel is synchronised, optionally inverted, and debounced with a saturating counter.
- Each channel produces a clean level plus one-cycle press and release strobes.
- Sits between the board pins and the core's load/start/step controls in top.

---
 rtl/btn_debounce_bank.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/btn_debounce_bank.sv
`timescale 1ns/1ps
// btn_debounce_bank
// ------------------
// Multi-channel button conditioner. Each raw pin is synchronised into the
// clk domain and has its polarity normalised so that 1 = pressed. It is then
// debounced by a saturating counter. The debounced level also produces
// registered one-cycle press and release strobes.
//
// Optional auto-repeat: define BTN_DEBOUNCE_REPEAT_EN to get per-channel hold
// counters driving btn_repeat. With the macro undefined, btn_repeat is tied
// low and no hold logic exists.
//
// Parameters:
//   N_CH            number of button channels
//   DEBOUNCE_CYCLES consecutive stable synced cycles needed to change level (>=1)
//   SYNC_STAGES     synchroniser depth (>=2)
//   ACTIVE_LOW      per-channel mask, bit=1 means the raw pin is active-low
//   HOLD_CYCLES     cycles after the press cycle before the first repeat strobe
//   REPEAT_CYCLES   period of the following repeat strobes
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_raw      raw pin levels, asynchronous to clk
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle strobe in the first cycle btn_level reads 1
//   btn_release  one-cycle strobe in the first cycle btn_level reads 0
//   btn_repeat   one-cycle auto-repeat strobes while held (feature only)
module btn_debounce_bank #(
    parameter int                N_CH            = 3,
    parameter int                DEBOUNCE_CYCLES = 16,
    parameter int                SYNC_STAGES     = 2,
    parameter logic [N_CH-1:0]   ACTIVE_LOW      = '0,
    parameter int                HOLD_CYCLES     = 64,
    parameter int                REPEAT_CYCLES   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value seen on the edge where the counter would reach DEBOUNCE_CYCLES.
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser. Flops reset to the inactive raw level, so an
    // active-low pin idling high does not look like a press on reset exit.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] pressed_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= ACTIVE_LOW;
            end
        end else begin
            sync_q[0] <= btn_raw;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign pressed_sync = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Debounce counters and strobe generation
    // ------------------------------------------------------------------
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0] level_d;
    logic [N_CH-1:0] press_d;
    logic [N_CH-1:0] release_d;

    always_comb begin
        level_d = btn_level;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pressed_sync[i] == btn_level[i]) begin
                // Any return to the current level restarts the count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                level_d[i] = ~btn_level[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        press_d   = level_d & ~btn_level;
        release_d = ~level_d & btn_level;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
        end
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat. The hold counter measures time since the press cycle
    // (or since the previous repeat). The phase selects the HOLD or REPEAT
    // target.
    // ------------------------------------------------------------------
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic {
        PH_HOLD,
        PH_REPEAT
    } phase_t;

    phase_t          phase_q [N_CH];
    phase_t          phase_d [N_CH];
    logic [HW-1:0]   hold_q  [N_CH];
    logic [HW-1:0]   hold_d  [N_CH];
    logic [N_CH-1:0] repeat_d;

    always_comb begin
        repeat_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            phase_d[i] = phase_q[i];
            hold_d[i]  = hold_q[i];
            // The counter is held clear in the press cycle and stays clear
            // on the releasing edge. Release therefore cancels a pending
            // repeat, and no repeat appears in the release cycle.
            if (!btn_level[i] || !level_d[i]) begin
                hold_d[i]  = '0;
                phase_d[i] = PH_HOLD;
            end else if (hold_q[i] == ((phase_q[i] == PH_HOLD) ? HOLD_LAST : REP_LAST)) begin
                repeat_d[i] = 1'b1;
                hold_d[i]   = '0;
                phase_d[i]  = PH_REPEAT;
            end else begin
                hold_d[i] = hold_q[i] + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                phase_q[i] <= PH_HOLD;
                hold_q[i]  <= '0;
            end
            btn_repeat <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                phase_q[i] <= phase_d[i];
                hold_q[i]  <= hold_d[i];
            end
            btn_repeat <= repeat_d;
        end
    end
`else
    assign btn_repeat = '0;
`endif

endmodule
